// File: rtl/seq_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu_pkg                                                  |
// | Description : Shared types for the sequential ALU: 4-bit opcode encoding,  |
// |               FSM state encoding and a small opcode-class helper.          |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_MOD  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_NOT  = 4'h8,
    OP_NAND = 4'h9,
    OP_NOR  = 4'hA,
    OP_XNOR = 4'hB,
    OP_SHL  = 4'hC,
    OP_SHR  = 4'hD,
    OP_ROL  = 4'hE,
    OP_INC  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_divmod(input opcode_e op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu_if                                                   |
// | Description : Operand/result handshake bundle of the sequential ALU.       |
// |               master: a, b, s, in_valid, out_ready driven; rest observed.  |
// |               slave : in_ready, y, carry, zero, err, out_valid driven.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface seq_alu_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [3:0]         s;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] y;
  logic               carry;
  logic               zero;
  logic               err;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output a, b, s, in_valid, out_ready,
    input  in_ready, y, carry, zero, err, out_valid
  );

  modport slave (
    input  a, b, s, in_valid, out_ready,
    output in_ready, y, carry, zero, err, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/seq_alu_div.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu_div                                                  |
// | Description : Iterative restoring divider, one quotient bit per cycle.     |
// |               Present only when SEQ_ALU_DIV_EN is defined.                 |
// | Ports       : clk, rst (sync, active-high), start_i, dividend_i,           |
// |               divisor_i -> done_o, quotient_o, remainder_o                 |
// |               done_o is high in the WIDTH-th cycle after start_i; the      |
// |               result outputs are valid in that same cycle.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`ifdef SEQ_ALU_DIV_EN
module seq_alu_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_restore;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  // Shift the next dividend bit into the partial remainder and try a subtract;
  // a borrow (MSB set) means the subtract is undone and the quotient bit is 0.
  assign w_shift   = {rem_q, quo_q[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, dvs_q};
  assign w_restore = w_trial[WIDTH];
  assign w_rem_nxt = w_restore ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nxt = {quo_q[WIDTH-2:0], ~w_restore};

  assign done_o      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign quotient_o  = w_quo_nxt;
  assign remainder_o = w_rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      quo_q <= w_quo_nxt;
      rem_q <= w_rem_nxt;
      cnt_q <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end
endmodule
`endif
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_alu                                                      |
// | Description : Sequential ALU with valid/ready handshake. Single-cycle ops  |
// |               complete one cycle after acceptance; MUL (shift-add) and     |
// |               DIV/MOD (restoring divider) take WIDTH extra BUSY cycles.    |
// |               Macro SEQ_ALU_DIV_EN builds the divider; without it DIV/MOD  |
// |               return y=0, err=1 in one cycle.                              |
// | Ports       : clk, rst (sync, active-high), bus_io (seq_alu_if.slave)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_alu_if.slave bus_io
);
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  state_e               state_q, state_d;
  opcode_e              op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   y_q, y_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic                 err_q, err_d;

  opcode_e              w_op_in;
  logic                 w_multi_in;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_sc_y;
  logic                 w_sc_carry;
  logic                 w_sc_err;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [2*WIDTH-1:0]   w_busy_y;
  logic                 w_last;
  logic                 w_div_done;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  assign w_op_in = opcode_e'(bus_io.s);
  // Division by zero never enters BUSY: it is resolved as a single-cycle error.
  assign w_multi_in = (w_op_in == OP_MUL) ||
                      (DIV_EN && is_divmod(w_op_in) && (bus_io.b != '0));

`ifdef SEQ_ALU_DIV_EN
  logic w_div_start;
  assign w_div_start = (state_q == ST_IDLE) && bus_io.in_valid &&
                       is_divmod(w_op_in) && (bus_io.b != '0);

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (w_div_start),
    .dividend_i  (bus_io.a),
    .divisor_i   (bus_io.b),
    .done_o      (w_div_done),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );
`else
  assign w_div_done = 1'b0;
  assign w_quo      = '0;
  assign w_rem      = '0;
`endif

  // Single-cycle result, computed straight from the bus operands.
  always_comb begin
    w_sc_y     = '0;
    w_sc_carry = 1'b0;
    w_sc_err   = 1'b0;
    w_sum      = '0;
    case (w_op_in)
      OP_ADD: begin
        w_sum            = {1'b0, bus_io.a} + {1'b0, bus_io.b};
        w_sc_y[WIDTH:0]  = w_sum;
        w_sc_carry       = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_sc_y[WIDTH-1:0] = bus_io.a - bus_io.b;
        w_sc_carry        = bus_io.a < bus_io.b;
      end
      OP_DIV, OP_MOD: begin
        w_sc_err = 1'b1;
        if (DIV_EN) w_sc_y[WIDTH-1:0] = '1;
      end
      OP_AND:  w_sc_y[WIDTH-1:0] = bus_io.a & bus_io.b;
      OP_OR:   w_sc_y[WIDTH-1:0] = bus_io.a | bus_io.b;
      OP_XOR:  w_sc_y[WIDTH-1:0] = bus_io.a ^ bus_io.b;
      OP_NOT:  w_sc_y[WIDTH-1:0] = ~bus_io.a;
      OP_NAND: w_sc_y[WIDTH-1:0] = ~(bus_io.a & bus_io.b);
      OP_NOR:  w_sc_y[WIDTH-1:0] = ~(bus_io.a | bus_io.b);
      OP_XNOR: w_sc_y[WIDTH-1:0] = ~(bus_io.a ^ bus_io.b);
      OP_SHL: begin
        w_sc_y[WIDTH-1:0] = {bus_io.a[WIDTH-2:0], 1'b0};
        w_sc_carry        = bus_io.a[WIDTH-1];
      end
      OP_SHR: begin
        w_sc_y[WIDTH-1:0] = {1'b0, bus_io.a[WIDTH-1:1]};
        w_sc_carry        = bus_io.a[0];
      end
      OP_ROL: begin
        w_sc_y[WIDTH-1:0] = {bus_io.a[WIDTH-2:0], bus_io.a[WIDTH-1]};
        w_sc_carry        = bus_io.a[WIDTH-1];
      end
      OP_INC: begin
        w_sum           = {1'b0, bus_io.a} + (WIDTH+1)'(1);
        w_sc_y[WIDTH:0] = w_sum;
        w_sc_carry      = w_sum[WIDTH];
      end
      default: ;
    endcase
  end

  // Shift-add: one multiplier bit consumed per BUSY cycle, LSB first.
  assign w_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    w_busy_y = w_acc_nxt;
    if (op_q == OP_DIV)      w_busy_y = {{WIDTH{1'b0}}, w_quo};
    else if (op_q == OP_MOD) w_busy_y = {{WIDTH{1'b0}}, w_rem};
  end

  assign w_last = (op_q == OP_MUL) ? (cnt_q == CNT_W'(WIDTH - 1)) : w_div_done;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    y_d      = y_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.in_valid) begin
          op_d     = w_op_in;
          cnt_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, bus_io.a};
          mplier_d = bus_io.b;
          acc_d    = '0;
          if (w_multi_in) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DONE;
            y_d     = w_sc_y;
            carry_d = w_sc_carry;
            err_d   = w_sc_err;
            zero_d  = (w_sc_y == '0);
          end
        end
      end
      ST_BUSY: begin
        cnt_d    = cnt_q + 1'b1;
        acc_d    = w_acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (w_last) begin
          state_d = ST_DONE;
          y_d     = w_busy_y;
          carry_d = 1'b0;
          err_d   = 1'b0;
          zero_d  = (w_busy_y == '0);
        end
      end
      ST_DONE: begin
        if (bus_io.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      y_q      <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      y_q      <= y_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign bus_io.in_ready  = (state_q == ST_IDLE);
  assign bus_io.out_valid = (state_q == ST_DONE);
  assign bus_io.y         = y_q;
  assign bus_io.carry     = carry_q;
  assign bus_io.zero      = zero_q;
  assign bus_io.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_alu                                                   |
// | Description : Self-checking bench for seq_alu (WIDTH=4): vector table,     |
// |               random ops against a behavioural model, hold/retire and      |
// |               reset-abort sequences. Honours SEQ_ALU_DIV_EN.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_alu;
  localparam int W = 4;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t sb[$];
  vec_t tbl[18];

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    vec_t r;
    logic [4:0] sum;
    r.a = a; r.b = b; r.s = s; r.y = '0; r.c = 1'b0; r.e = 1'b0; r.lat = 1;
    sum = '0;
    case (s)
      4'h0: begin sum = {1'b0, a} + {1'b0, b}; r.y = {3'b0, sum}; r.c = sum[4]; end
      4'h1: begin r.y = {4'b0, 4'(a - b)}; r.c = (a < b); end
      4'h2: begin r.y = {4'b0, a} * {4'b0, b}; r.lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
      4'h3: if (b == 0) begin r.y = 8'h0F; r.e = 1'b1; end
            else begin r.y = {4'b0, a / b}; r.lat = W + 1; end
      4'h4: if (b == 0) begin r.y = 8'h0F; r.e = 1'b1; end
            else begin r.y = {4'b0, a % b}; r.lat = W + 1; end
`else
      4'h3, 4'h4: r.e = 1'b1;
`endif
      4'h5: r.y = {4'b0, a & b};
      4'h6: r.y = {4'b0, a | b};
      4'h7: r.y = {4'b0, a ^ b};
      4'h8: r.y = {4'b0, ~a};
      4'h9: r.y = {4'b0, ~(a & b)};
      4'hA: r.y = {4'b0, ~(a | b)};
      4'hB: r.y = {4'b0, ~(a ^ b)};
      4'hC: begin r.y = {4'b0, a[2:0], 1'b0}; r.c = a[3]; end
      4'hD: begin r.y = {5'b0, a[3:1]}; r.c = a[0]; end
      4'hE: begin r.y = {4'b0, a[2:0], a[3]}; r.c = a[3]; end
      default: begin sum = {1'b0, a} + 5'd1; r.y = {3'b0, sum}; r.c = sum[4]; end
    endcase
    r.z = (r.y == 0);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after retire.
  task automatic run_op(input vec_t v, input int hold);
    vec_t e;
    int   lat;
    chk("idle_in_ready", {31'b0, bus.in_ready}, 1);
    bus.a = v.a; bus.b = v.b; bus.s = v.s; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    sb.push_back(v);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      chk("busy_in_ready", {31'b0, bus.in_ready}, 0);
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk($sformatf("latency s=%0h", e.s), lat, e.lat);
    chk($sformatf("y a=%0h b=%0h s=%0h", e.a, e.b, e.s), {24'b0, bus.y}, {24'b0, e.y});
    chk($sformatf("carry s=%0h", e.s), {31'b0, bus.carry}, {31'b0, e.c});
    chk($sformatf("zero s=%0h", e.s), {31'b0, bus.zero}, {31'b0, e.z});
    chk($sformatf("err s=%0h", e.s), {31'b0, bus.err}, {31'b0, e.e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, bus.out_valid}, 1);
      chk("hold_y", {24'b0, bus.y}, {24'b0, e.y});
      chk("hold_carry", {31'b0, bus.carry}, {31'b0, e.c});
    end
    // Offer a new op on the retiring edge; it must not be taken.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("retire_out_valid", {31'b0, bus.out_valid}, 0);
    chk("retire_in_ready", {31'b0, bus.in_ready}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'h8, 4'h2, 4'h0, 8'h0A, 1'b0, 1'b0, 1'b0, 1};
    tbl[1]  = '{4'hC, 4'hF, 4'h2, 8'hB4, 1'b0, 1'b0, 1'b0, 5};
`ifdef SEQ_ALU_DIV_EN
    tbl[2]  = '{4'hC, 4'h0, 4'h3, 8'h0F, 1'b0, 1'b0, 1'b1, 1};
    tbl[3]  = '{4'hD, 4'h3, 4'h4, 8'h01, 1'b0, 1'b0, 1'b0, 5};
    tbl[4]  = '{4'hC, 4'h2, 4'h3, 8'h06, 1'b0, 1'b0, 1'b0, 5};
`else
    tbl[2]  = '{4'hC, 4'h0, 4'h3, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    tbl[3]  = '{4'hD, 4'h3, 4'h4, 8'h00, 1'b0, 1'b1, 1'b1, 1};
    tbl[4]  = '{4'hC, 4'h2, 4'h3, 8'h00, 1'b0, 1'b1, 1'b1, 1};
`endif
    tbl[5]  = '{4'h2, 4'hC, 4'h1, 8'h06, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{4'hF, 4'h1, 4'h0, 8'h10, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{4'hF, 4'h0, 4'hF, 8'h10, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{4'h5, 4'h5, 4'h1, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[9]  = '{4'h9, 4'h0, 4'hC, 8'h02, 1'b1, 1'b0, 1'b0, 1};
    tbl[10] = '{4'h9, 4'h0, 4'hD, 8'h04, 1'b1, 1'b0, 1'b0, 1};
    tbl[11] = '{4'h9, 4'h0, 4'hE, 8'h03, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{4'hF, 4'h0, 4'h8, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[13] = '{4'hA, 4'h6, 4'hB, 8'h03, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{4'hF, 4'hF, 4'h9, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[15] = '{4'h0, 4'h7, 4'h2, 8'h00, 1'b0, 1'b1, 1'b0, 5};
    tbl[16] = '{4'h0, 4'h0, 4'hA, 8'h0F, 1'b0, 1'b0, 1'b0, 1};
    tbl[17] = '{4'hF, 4'hF, 4'h2, 8'hE1, 1'b0, 1'b0, 1'b0, 5};

    bus.a = '0; bus.b = '0; bus.s = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
    chk("rst_y", {24'b0, bus.y}, 0);
    chk("rst_flags", {29'b0, bus.carry, bus.zero, bus.err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_op(tbl[i], 0);

    // Result held while the consumer stalls.
    run_op(model(4'h2, 4'hC, 4'h1), 3);
    run_op(model(4'h3, 4'h5, 4'h2), 2);

    for (int i = 0; i < 24; i++)
      run_op(model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15))), i % 3);

    // Reset in the second BUSY cycle of a MUL aborts it; y (0xE1 before) clears.
    run_op(tbl[17], 0);
    bus.a = 4'hC; bus.b = 4'hF; bus.s = 4'h2; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", {31'b0, bus.in_ready}, 1);
    chk("abort_out_valid", {31'b0, bus.out_valid}, 0);
    chk("abort_y", {24'b0, bus.y}, 0);
    chk("abort_flags", {29'b0, bus.carry, bus.zero, bus.err}, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_out_valid", {31'b0, bus.out_valid}, 0);
    end
    bus.out_ready = 1'b0;
    run_op(tbl[0], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
